// File: rtl/load_store_ctrl.sv
// Sequences core loads/stores onto a word-wide memory without byte enables, doing RMW for sub-word stores.
// Latency: misaligned 1 cycle, load/word store 2, byte/half store 3, plus any memAck wait states.
// Backpressure: reqReady only in IDLE; memory stalls by withholding memAck, bounded by ACK_TIMEOUT.

`ifndef LOAD_STORE_BYTE
`define LOAD_STORE_BYTE 2'b00
`endif
`ifndef LOAD_STORE_HALF
`define LOAD_STORE_HALF 2'b01
`endif

// Byte/half extract and merge for a word-addressed memory; purely combinational.
module loadStoreUnit (
    input  logic [31:0] readWord,
    input  logic [1:0]  offset,
    input  logic [1:0]  len,
    input  logic        signExtend,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] laneMask;

    assign shamt   = {offset, 3'b000};
    assign shifted = readWord >> shamt;

    always_comb begin
        loadData   = readWord;
        mergedWord = storeData;
        laneMask   = 32'hFFFF_FFFF;
        case (len)
            `LOAD_STORE_BYTE: begin
                laneMask   = 32'h0000_00FF << shamt;
                loadData   = {{24{signExtend & shifted[7]}}, shifted[7:0]};
                mergedWord = (readWord & ~laneMask) | ((storeData & 32'h0000_00FF) << shamt);
            end
            `LOAD_STORE_HALF: begin
                laneMask   = 32'h0000_FFFF << shamt;
                loadData   = {{16{signExtend & shifted[15]}}, shifted[15:0]};
                mergedWord = (readWord & ~laneMask) | ((storeData & 32'h0000_FFFF) << shamt);
            end
            default: begin
                loadData   = readWord;
                mergedWord = storeData;
            end
        endcase
    end
endmodule

module load_store_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [1:0]  reqLen,
    input  logic        reqSignExtend,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respMisaligned,
    output logic        respBusError,
    output logic [31:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    input  logic        memAck
);
    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} stateT;

    stateT         state, stateNext;
    logic [31:0]   addrQ, wdataQ, dataReg;
    logic [1:0]    lenQ;
    logic          signQ, writeQ, misQ, busErrQ;
    logic [CW-1:0] cnt;

    logic          reqSubWord, reqMis, subWordQ, timedOut, latchRead, setErr;
    logic [31:0]   loadData, mergedWord;

    assign reqSubWord = (reqLen == `LOAD_STORE_BYTE) || (reqLen == `LOAD_STORE_HALF);
    assign reqMis     = (reqLen == `LOAD_STORE_BYTE) ? 1'b0 :
                        (reqLen == `LOAD_STORE_HALF) ? (reqAddr[1:0] == 2'd3) :
                                                       (reqAddr[1:0] != 2'd0);
    assign subWordQ   = (lenQ == `LOAD_STORE_BYTE) || (lenQ == `LOAD_STORE_HALF);
    // An ack on the last allowed cycle takes priority over the timeout.
    assign timedOut   = (ACK_TIMEOUT != 0) && !memAck && (cnt == CNT_LAST);

    loadStoreUnit lsu (
        .readWord   (dataReg),
        .offset     (addrQ[1:0]),
        .len        (lenQ),
        .signExtend (signQ),
        .storeData  (wdataQ),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    always_comb begin
        stateNext = state;
        latchRead = 1'b0;
        setErr    = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (reqMis)                        stateNext = RESP;
                    else if (!reqWrite || reqSubWord)  stateNext = RD;
                    else                               stateNext = WR;
                end
            end
            RD: begin
                if (memAck) begin
                    latchRead = 1'b1;
                    stateNext = writeQ ? WR : RESP;
                end else if (timedOut) begin
                    setErr    = 1'b1;
                    stateNext = RESP;
                end
            end
            WR: begin
                if (memAck) begin
                    stateNext = RESP;
                end else if (timedOut) begin
                    setErr    = 1'b1;
                    stateNext = RESP;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addrQ   <= '0;
            wdataQ  <= '0;
            dataReg <= '0;
            lenQ    <= '0;
            signQ   <= 1'b0;
            writeQ  <= 1'b0;
            misQ    <= 1'b0;
            busErrQ <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= stateNext;
            if (stateNext != state)
                cnt <= '0;
            else if (state == RD || state == WR)
                cnt <= cnt + 1'b1;
            if (state == IDLE && reqValid) begin
                addrQ   <= reqAddr;
                wdataQ  <= reqWriteData;
                lenQ    <= reqLen;
                signQ   <= reqSignExtend;
                writeQ  <= reqWrite;
                misQ    <= reqMis;
                busErrQ <= 1'b0;
            end
            if (latchRead)
                dataReg <= memReadData;
            if (setErr)
                busErrQ <= 1'b1;
        end
    end

    assign reqReady       = (state == IDLE);
    assign respValid      = (state == RESP);
    assign respMisaligned = (state == RESP) && misQ;
    assign respBusError   = (state == RESP) && busErrQ;
    assign respData       = ((state == RESP) && !writeQ && !misQ && !busErrQ) ? loadData : 32'd0;
    assign memAddr        = {addrQ[31:2], 2'b00};
    assign memRead        = (state == RD);
    assign memWrite       = (state == WR);
    // Word stores never read, so the merged word is only meaningful after an RMW read.
    assign memWriteData   = (state == WR) ? (subWordQ ? mergedWord : wdataQ) : 32'd0;
endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed test-plan steps followed by random accesses, checked against a word-array memory model.
`ifndef LOAD_STORE_BYTE
`define LOAD_STORE_BYTE 2'b00
`endif
`ifndef LOAD_STORE_HALF
`define LOAD_STORE_HALF 2'b01
`endif

module tb_load_store_ctrl;
    localparam int TO = 6;
    localparam logic [1:0] LB = `LOAD_STORE_BYTE;
    localparam logic [1:0] LH = `LOAD_STORE_HALF;
    localparam logic [1:0] LW = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqSignExtend;
    logic [31:0] reqAddr, reqWriteData;
    logic [1:0]  reqLen;
    logic        respValid, respMisaligned, respBusError;
    logic [31:0] respData;
    logic [31:0] memAddr, memWriteData, memReadData;
    logic        memRead, memWrite, memAck;

    logic [31:0] memModel [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqLen(reqLen), .reqSignExtend(reqSignExtend),
        .reqWriteData(reqWriteData),
        .respValid(respValid), .respData(respData),
        .respMisaligned(respMisaligned), .respBusError(respBusError),
        .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
        .memWriteData(memWriteData), .memReadData(memReadData), .memAck(memAck)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge one cycle after the response.
    task automatic doReq(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                         input logic sx, input logic [31:0] wdat, input int dly, input logic noAck);
        int unsigned off, size, idx;
        logic [31:0] mask, old, expWord, expData, v;
        logic mis, rmw, done, ack;
        int expLat, expRd, expWr, sawRd, sawWr;

        off  = addr[1:0];
        size = (len == LB) ? 1 : (len == LH) ? 2 : 4;
        mis  = (off + size) > 4;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        idx  = addr[9:2];
        old  = memModel[idx];
        rmw  = wr && (size < 4);
        expWord = (old & ~(mask << (8 * off))) | ((wdat & mask) << (8 * off));
        v = (old >> (8 * off)) & mask;
        if (sx && size < 4 && v[8 * size - 1]) v = v | ~mask;
        expData = (!wr && !mis && !noAck) ? v : 32'd0;

        if (mis) begin
            expRd = 0; expWr = 0; expLat = 1;
        end else if (noAck) begin
            expRd  = (!wr || rmw) ? TO : 0;
            expWr  = (wr && !rmw) ? TO : 0;
            expLat = TO + 1;
        end else begin
            expRd  = (!wr || rmw) ? dly + 1 : 0;
            expWr  = wr ? dly + 1 : 0;
            expLat = expRd + expWr + 1;
        end

        check("req_ready_idle", {31'd0, reqReady}, 32'd1);
        reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqLen = len;
        reqSignExtend = sx; reqWriteData = wdat;
        @(posedge clk);
        #1 reqValid = 1'b0;
        reqAddr = $urandom; reqWriteData = $urandom; reqLen = 2'($urandom);

        sawRd = 0; sawWr = 0; done = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            ack = 1'b0;
            if (memRead) begin
                sawRd++;
                check("strobe_exclusive", {31'd0, memWrite}, 32'd0);
                check("rd_addr", memAddr, {addr[31:2], 2'b00});
                ack = !noAck && (sawRd == dly + 1);
            end
            if (memWrite) begin
                sawWr++;
                check("wr_addr", memAddr, {addr[31:2], 2'b00});
                check("wr_data", memWriteData, expWord);
                ack = !noAck && (sawWr == dly + 1);
                if (ack) memModel[idx] = expWord;
            end
            memAck = ack;
            memReadData = (ack && memRead) ? old : $urandom;
            if (respValid) begin
                check("resp_latency", cyc, expLat);
                check("resp_data", respData, expData);
                check("resp_misaligned", {31'd0, respMisaligned}, {31'd0, mis});
                check("resp_buserror", {31'd0, respBusError}, {31'd0, noAck && !mis});
                check("read_cycles", sawRd, expRd);
                check("write_cycles", sawWr, expWr);
                done = 1'b1;
                break;
            end
        end
        memAck = 1'b0;
        check("resp_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("resp_one_cycle", {31'd0, respValid}, 32'd0);
        check("ready_after_resp", {31'd0, reqReady}, 32'd1);
        check("idle_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("idle_resp_data", respData, 32'd0);
        check("idle_flags", {30'd0, respMisaligned, respBusError}, 32'd0);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 256; i++) memModel[i] = $urandom;
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqLen = '0;
        reqSignExtend = 1'b0; reqWriteData = '0; memReadData = '0; memAck = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, reqReady}, 32'd1);
        check("rst_resp", {29'd0, respValid, respMisaligned, respBusError}, 32'd0);
        check("rst_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("rst_mem_addr", memAddr, 32'd0);
        check("rst_mem_wdata", memWriteData, 32'd0);
        check("rst_resp_data", respData, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Sub-word loads from a known word.
        memModel[8'h40] = 32'h80FF_7F01;
        doReq(1'b0, 32'h101, LB, 1'b1, 32'h0, 0, 1'b0);
        doReq(1'b0, 32'h103, LB, 1'b0, 32'h0, 0, 1'b0);
        doReq(1'b0, 32'h101, LH, 1'b1, 32'h0, 0, 1'b0);
        doReq(1'b0, 32'h102, LH, 1'b0, 32'h0, 0, 1'b0);
        doReq(1'b0, 32'h100, LW, 1'b0, 32'h0, 0, 1'b0);

        // Full-word store then RMW byte/half stores.
        doReq(1'b1, 32'h100, LW, 1'b0, 32'h1122_3344, 0, 1'b0);
        doReq(1'b1, 32'h102, LB, 1'b0, 32'h0000_00AB, 0, 1'b0);
        doReq(1'b1, 32'h100, LW, 1'b0, 32'h1122_3344, 0, 1'b0);
        doReq(1'b1, 32'h101, LH, 1'b0, 32'h0000_BEEF, 0, 1'b0);
        doReq(1'b0, 32'h100, LW, 1'b0, 32'h0, 0, 1'b0);

        // Misaligned accesses.
        doReq(1'b0, 32'h103, LH, 1'b1, 32'h0, 0, 1'b0);
        doReq(1'b0, 32'h102, LW, 1'b0, 32'h0, 0, 1'b0);
        doReq(1'b1, 32'h101, 2'b11, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

        // Ack on the last allowed cycle, then a full timeout, then normal traffic.
        doReq(1'b1, 32'h10A, LB, 1'b0, 32'h0000_0055, 5, 1'b0);
        doReq(1'b0, 32'h104, LW, 1'b0, 32'h0, 0, 1'b1);
        doReq(1'b1, 32'h105, LB, 1'b0, 32'h0000_0077, 0, 1'b1);
        doReq(1'b1, 32'h108, LW, 1'b0, 32'hCAFE_F00D, 0, 1'b1);
        doReq(1'b0, 32'h108, LW, 1'b0, 32'h0, 1, 1'b0);

        // Reset while an RMW write is pending.
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h115; reqLen = LB;
        reqSignExtend = 1'b0; reqWriteData = 32'h0000_005A;
        @(posedge clk);
        #1 reqValid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            memAck = memRead;
            memReadData = memModel[8'h45];
            if (memWrite) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_wr_reached", {31'd0, seen}, 32'd1);
        memAck = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("rst_mid_resp", {31'd0, respValid}, 32'd0);
        check("rst_mid_ready", {31'd0, reqReady}, 32'd1);
        reset = 1'b0;
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        check("stray_ack_resp", {31'd0, respValid}, 32'd0);
        check("stray_ack_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("stray_ack_ready", {31'd0, reqReady}, 32'd1);
        doReq(1'b0, 32'h114, LW, 1'b0, 32'h0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            doReq(1'($urandom), 32'h100 + 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                  1'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
